// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: tracks the longest matched prefix of PATTERN
// (MSB first) using a next-state table built from PATTERN at elaboration.
module seq_detector_param #(
  parameter int unsigned PAT_LEN = 4,
  parameter logic [15:0] PATTERN = 16'h000D,
  parameter bit          OVERLAP = 1'b1,
  parameter bit          REG_OUT = 1'b0,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned ST_W   = $clog2(PAT_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic [ST_W-1:0]  state_o
);

  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
    $error("seq_detector_param: PAT_LEN must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W must be in 1..32");
  end

  localparam int unsigned NUM_ST = 2 ** ST_W;
  localparam int unsigned TAB_W  = 2 * NUM_ST * ST_W;
  localparam logic [ST_W-1:0] LAST_ST = ST_W'(PAT_LEN - 1);

  function automatic logic [31:0] low_mask(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

  // Longest prefix of PATTERN that is a suffix of (prefix k, b), capped below PAT_LEN so
  // the full-match case yields the longest proper border.
  function automatic int unsigned next_len(input int unsigned k, input bit b);
    logic [31:0]  pat32;
    logic [31:0]  s;
    int unsigned  lim;
    int unsigned  best;
    pat32 = 32'(PATTERN);
    s     = (((pat32 >> (PAT_LEN - k)) & low_mask(k)) << 1) | 32'(b);
    lim   = (k + 1 < PAT_LEN) ? k + 1 : PAT_LEN - 1;
    best  = 0;
    for (int unsigned l = 1; l <= lim; l++) begin
      if (((pat32 >> (PAT_LEN - l)) & low_mask(l)) == (s & low_mask(l))) best = l;
    end
    return best;
  endfunction

  function automatic logic [TAB_W-1:0] build_tab();
    logic [TAB_W-1:0] tab;
    int unsigned      nxt;
    tab = '0;
    for (int unsigned k = 0; k < PAT_LEN; k++) begin
      for (int unsigned b = 0; b < 2; b++) begin
        nxt = next_len(k, b[0]);
        if (k == PAT_LEN - 1 && b[0] == PATTERN[0] && !OVERLAP) nxt = 0;
        tab[(2 * k + b) * ST_W +: ST_W] = ST_W'(nxt);
      end
    end
    return tab;
  endfunction

  localparam logic [TAB_W-1:0] NEXT_TAB = build_tab();

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;
  logic             match;

  always_comb begin
    match   = in_valid && (state_q == LAST_ST) && (x == PATTERN[0]);
    state_d = state_q;
    if (in_valid) begin
      for (int i = 0; i < 2 * NUM_ST; i++) begin
        if ({state_q, x} == (ST_W + 1)'(i)) state_d = NEXT_TAB[i * ST_W +: ST_W];
      end
    end
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    y_d = match;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      cnt_q   <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign y         = REG_OUT ? y_q : match;
  assign match_cnt = cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: five variants share one stimulus stream.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset, x, in_valid, cnt_clr;

  logic       y_def, y_nov, y_reg, y_c2, y_one;
  logic [7:0] cnt_def, cnt_nov, cnt_reg, cnt_one;
  logic [1:0] cnt_c2;
  logic [1:0] st_def, st_nov, st_reg, st_c2, st_one;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_param u_def (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .y(y_def), .match_cnt(cnt_def), .state_o(st_def)
  );
  seq_detector_param #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .y(y_nov), .match_cnt(cnt_nov), .state_o(st_nov)
  );
  seq_detector_param #(.REG_OUT(1'b1)) u_reg (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .y(y_reg), .match_cnt(cnt_reg), .state_o(st_reg)
  );
  seq_detector_param #(.CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .y(y_c2), .match_cnt(cnt_c2), .state_o(st_c2)
  );
  seq_detector_param #(.PATTERN(16'h000F)) u_one (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .y(y_one), .match_cnt(cnt_one), .state_o(st_one)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic xv, input logic vv, input logic cc);
    @(negedge clk);
    x = xv;
    in_valid = vv;
    cnt_clr = cc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic xv);
    drive(xv, 1'b1, 1'b0);
    tick();
  endtask

  task automatic hard_reset();
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] a_bits;
    reset = 1'b1;
    x = 1'b0;
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    #12;
    chk("rst_state", 32'(st_def), 32'd0);
    chk("rst_cnt", 32'(cnt_def), 32'd0);
    chk("rst_y_def", 32'(y_def), 32'd0);
    chk("rst_y_reg", 32'(y_reg), 32'd0);
    reset = 1'b0;

    // Stream 1,1,0,1,1,0,1: overlap matches at bits 4 and 7, non-overlap only at bit 4.
    a_bits = 7'b1101101;
    for (int i = 0; i < 7; i++) begin
      drive(a_bits[6-i], 1'b1, 1'b0);
      chk("a_y_def", 32'(y_def), 32'(i == 3 || i == 6));
      chk("a_y_nov", 32'(y_nov), 32'(i == 3));
      chk("a_y_reg", 32'(y_reg), 32'(i == 4));
      tick();
      if (i == 3) begin
        chk("a_st_def_bit4", 32'(st_def), 32'd1);
        chk("a_st_nov_bit4", 32'(st_nov), 32'd0);
      end
    end
    chk("a_cnt_def", 32'(cnt_def), 32'd2);
    chk("a_cnt_nov", 32'(cnt_nov), 32'd1);
    chk("a_cnt_c2", 32'(cnt_c2), 32'd2);
    chk("a_cnt_one", 32'(cnt_one), 32'd0);
    chk("a_y_reg_after", 32'(y_reg), 32'd1);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("clr_cnt_def", 32'(cnt_def), 32'd0);
    chk("clr_state_kept", 32'(st_def), 32'd1);
    chk("clr_y_reg_one_pulse", 32'(y_reg), 32'd0);

    // Invalid gap in the middle of a match; state holds, Mealy y stays low.
    hard_reset();
    feed(1'b1);
    feed(1'b1);
    feed(1'b0);
    chk("b_st_pre_gap", 32'(st_def), 32'd3);
    for (int g = 0; g < 3; g++) begin
      drive(g[0], 1'b0, 1'b0);
      chk("b_y_gap", 32'(y_def), 32'd0);
      tick();
      chk("b_st_gap", 32'(st_def), 32'd3);
    end
    drive(1'b1, 1'b1, 1'b0);
    chk("b_y_resume", 32'(y_def), 32'd1);
    chk("b_y_reg_match_cycle", 32'(y_reg), 32'd0);
    tick();
    chk("b_y_reg_next", 32'(y_reg), 32'd1);
    chk("b_cnt_def", 32'(cnt_def), 32'd1);
    chk("b_cnt_reg", 32'(cnt_reg), 32'd1);
    chk("b_st_after", 32'(st_def), 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    chk("b_y_reg_single", 32'(y_reg), 32'd0);

    // Asynchronous reset between edges after 1,1,0 with a matching bit on the input.
    feed(1'b1);
    feed(1'b1);
    feed(1'b0);
    chk("d_st_pre", 32'(st_def), 32'd3);
    drive(1'b1, 1'b1, 1'b0);
    chk("d_y_pre", 32'(y_def), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("d_st_async", 32'(st_def), 32'd0);
    chk("d_cnt_async", 32'(cnt_def), 32'd0);
    chk("d_y_async", 32'(y_def), 32'd0);
    reset = 1'b0;
    tick();
    chk("d_st_first1", 32'(st_def), 32'd1);
    chk("d_cnt_no_match", 32'(cnt_def), 32'd0);
    drive(1'b1, 1'b1, 1'b0);
    chk("d_y_no_match", 32'(y_def), 32'd0);
    tick();
    feed(1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("d_y_full", 32'(y_def), 32'd1);
    tick();
    chk("d_cnt_full", 32'(cnt_def), 32'd1);

    // Two-bit counter saturates at 3; clear beats a simultaneous match.
    hard_reset();
    for (int r = 0; r < 5; r++) begin
      feed(1'b1);
      feed(1'b1);
      feed(1'b0);
      feed(1'b1);
      chk("c_cnt_c2", 32'(cnt_c2), (r < 3) ? 32'(r + 1) : 32'd3);
    end
    chk("c_cnt_def", 32'(cnt_def), 32'd5);
    feed(1'b1);
    feed(1'b1);
    feed(1'b0);
    drive(1'b1, 1'b1, 1'b1);
    chk("c_y_clr_cycle", 32'(y_def), 32'd1);
    tick();
    chk("c_cnt_c2_clr", 32'(cnt_c2), 32'd0);
    chk("c_cnt_def_clr", 32'(cnt_def), 32'd0);
    chk("c_st_clr", 32'(st_def), 32'd1);

    // All-ones pattern: every valid 1 after the first three matches.
    hard_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      chk("e_y_one", 32'(y_one), 32'(i >= 3));
      tick();
    end
    chk("e_cnt_one", 32'(cnt_one), 32'd3);
    chk("e_st_one", 32'(st_one), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
